grayscale_stage: RTL

//  Consumer stage behind the input pixel fifo (standard read mode, single clock).
//  - Pops 24-bit RGB pixels from the input fifo.
//  - Converts each pixel to 8-bit luma.
//  - Pushes the luma values into the downstream fifo.

---
 rtl/grayscale_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/grayscale_stage.sv
// RGB-to-luma stage between the input pixel fifo and the downstream luma fifo.
// Latency: 3 cycles pop-to-write minimum. Backpressure: reads are credit-limited so in-flight pixels always fit the output buffer.
module grayscale_stage #(
    parameter int DATA_IN_WIDTH  = 24,
    parameter int DATA_OUT_WIDTH = 8,
    parameter int BUF_DEPTH      = 4,
    parameter int FRAME_PIXELS   = 388800
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_empty,
    output logic                              in_rd_en,
    input  logic                              in_valid,
    input  logic [DATA_IN_WIDTH-1:0]          in_dout,
    input  logic                              out_full,
    output logic                              out_wr_en,
    output logic [DATA_OUT_WIDTH-1:0]         out_din,
    output logic [$clog2(FRAME_PIXELS+1)-1:0] pixel_count,
    output logic                              frame_done
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int INF_W = $clog2(BUF_DEPTH + 1);
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    logic                      rd_pending_q;
    logic                      sum_vld_q, sum_vld_d;
    logic [15:0]               sum_q, sum_d;
    logic [DATA_OUT_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [INF_W-1:0]          buf_cnt_q, buf_cnt_d;
    logic [INF_W-1:0]          inflight_q, inflight_d;
    logic [CNT_W-1:0]          pixel_count_q, pixel_count_d;
    logic                      frame_done_q, frame_done_d;

    logic [15:0] r16, g16, b16;
    logic        buf_empty;

    assign r16 = {8'd0, in_dout[23:16]};
    assign g16 = {8'd0, in_dout[15:8]};
    assign b16 = {8'd0, in_dout[7:0]};

    assign buf_empty = (buf_cnt_q == '0);

    // Reset gates both handshakes so nothing is popped or written while the pipe is being cleared.
    assign out_wr_en = !reset && !buf_empty && !out_full;
    assign in_rd_en  = !reset && !in_empty &&
                       ((inflight_q < INF_W'(BUF_DEPTH)) || out_wr_en);

    assign out_din     = mem_q[rd_ptr_q];
    assign pixel_count = pixel_count_q;
    assign frame_done  = frame_done_q;

    always_comb begin
        sum_vld_d     = rd_pending_q && in_valid;
        sum_d         = sum_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        buf_cnt_d     = buf_cnt_q;
        inflight_d    = inflight_q;
        pixel_count_d = pixel_count_q;
        frame_done_d  = 1'b0;

        // Max 255*256 = 65280, so 16 bits never overflow.
        if (sum_vld_d) begin
            sum_d = 16'd77 * r16 + 16'd150 * g16 + 16'd29 * b16;
        end

        if (sum_vld_q) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (out_wr_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({sum_vld_q, out_wr_en})
            2'b10:   buf_cnt_d = buf_cnt_q + INF_W'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - INF_W'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase

        case ({in_rd_en, out_wr_en})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        if (out_wr_en) begin
            if (pixel_count_q == CNT_W'(FRAME_PIXELS - 1)) begin
                pixel_count_d = '0;
                frame_done_d  = 1'b1;
            end else begin
                pixel_count_d = pixel_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pending_q  <= 1'b0;
            sum_vld_q     <= 1'b0;
            sum_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            buf_cnt_q     <= '0;
            inflight_q    <= '0;
            pixel_count_q <= '0;
            frame_done_q  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_pending_q  <= in_rd_en;
            sum_vld_q     <= sum_vld_d;
            sum_q         <= sum_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            buf_cnt_q     <= buf_cnt_d;
            inflight_q    <= inflight_d;
            pixel_count_q <= pixel_count_d;
            frame_done_q  <= frame_done_d;
            if (sum_vld_q) begin
                mem_q[wr_ptr_q] <= DATA_OUT_WIDTH'(sum_q >> 8);
            end
        end
    end

endmodule
